// File: rtl/opload_pkg.sv
// Shared constants and state encoding for the operand nibble loader.
// Nibble indices follow the pushbutton bit order.
package opload_pkg;

    localparam int NIB_A_LO = 0;
    localparam int NIB_A_HI = 1;
    localparam int NIB_B_LO = 2;
    localparam int NIB_B_HI = 3;

    localparam logic [3:0] ALL_LOADED = 4'hF;

    typedef enum logic {
        COLLECT = 1'b0,
        VALID   = 1'b1
    } state_t;

endpackage

// File: rtl/pb_debounce.sv
// One pushbutton: 2-flop sync, stable-level debounce counter, registered press pulse.
// Press pulse appears 2 + DEBOUNCE_CYCLES cycles after a clean raw rising edge.
module pb_debounce #(
    parameter  int DEBOUNCE_CYCLES = 16,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 != level) begin
                // Accept the new level only after it has held for the full window.
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                    rise  <= sync2;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/operand_nibble_loader.sv
// Builds operands a/b one nibble per debounced press; op_valid/op_ready handshake when full.
// Optional OPLOAD_REPRESS_ERR_EN: re-press of a loaded nibble is ignored and raises sticky err.
module operand_nibble_loader
    import opload_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] pb,
    input  logic [3:0] y,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [3:0] loaded,
    output logic       op_valid,
    input  logic       op_ready,
    output logic       err
);

    logic [3:0] y_s1;
    logic [3:0] y_s2;
    logic [3:0] press;
    logic [3:0] load_mask;
    logic       clr_loaded;
    state_t     state;
    state_t     state_nxt;

    for (genvar i = 0; i < 4; i++) begin : g_pb
        pb_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_pb_debounce (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (pb[i]),
            .rise (press[i])
        );
    end

`ifdef OPLOAD_REPRESS_ERR_EN
    logic err_set;
`endif

    always_comb begin
        state_nxt  = state;
        load_mask  = '0;
        clr_loaded = 1'b0;
`ifdef OPLOAD_REPRESS_ERR_EN
        err_set    = 1'b0;
`endif
        case (state)
            COLLECT: begin
`ifdef OPLOAD_REPRESS_ERR_EN
                load_mask = press & ~loaded;
                err_set   = |(press & loaded);
`else
                load_mask = press;
`endif
                if (loaded == ALL_LOADED) begin
                    state_nxt = VALID;
                end
            end
            VALID: begin
                // Presses here are dropped, including one coinciding with the handshake.
                if (op_ready) begin
                    state_nxt  = COLLECT;
                    clr_loaded = 1'b1;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_s1     <= '0;
            y_s2     <= '0;
            a        <= '0;
            b        <= '0;
            loaded   <= '0;
            op_valid <= 1'b0;
        end else begin
            y_s1     <= y;
            y_s2     <= y_s1;
            op_valid <= (state_nxt == VALID);
            if (clr_loaded) begin
                loaded <= '0;
            end else begin
                loaded <= loaded | load_mask;
            end
            if (load_mask[NIB_A_LO]) a[3:0] <= y_s2;
            if (load_mask[NIB_A_HI]) a[7:4] <= y_s2;
            if (load_mask[NIB_B_LO]) b[3:0] <= y_s2;
            if (load_mask[NIB_B_HI]) b[7:4] <= y_s2;
        end
    end

`ifdef OPLOAD_REPRESS_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (clr_loaded) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
